// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D memory port arbiter: FSM state, owner encoding and
// the starvation counter width/saturating increment.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    ACK  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int unsigned STARVE_W = 4;

  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] cnt,
                                                  input logic [STARVE_W-1:0] lim);
    return (cnt >= lim) ? lim : cnt + STARVE_W'(1);
  endfunction

endpackage

// File: rtl/mem_port_arb_if.sv
// Requester and memory-side signals of mem_port_arb.
// slave = the arbiter; master = fetch/access stages plus the memory.
interface mem_port_arb_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned SW = DW / 8;

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_kill;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          if_stall;
  logic          if_err;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [SW-1:0] d_wstrb;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          d_stall;
  logic          d_err;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_kill,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output if_ack, if_rdata, if_stall, if_err,
    output d_ack, d_rdata, d_stall, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output if_req, if_addr, if_kill,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  if_ack, if_rdata, if_stall, if_err,
    input  d_ack, d_rdata, d_stall, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

endinterface

// File: rtl/mem_port_arb.sv
// Arbitrates one memory port between instruction fetch (I) and data access (D).
// Define MEM_ARB_TIMEOUT_EN to abort transactions stuck in REQ/RESP for TIMEOUT_CYC cycles.
module mem_port_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned STARVE_MAX  = 4,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic          clk,
  input  logic          rst,
  mem_port_arb_if.slave bus
);

  localparam int unsigned        SW         = DW / 8;
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("mem_port_arb: STARVE_MAX must be 1..15 and TIMEOUT_CYC at least 2");
  end

  state_e              state_q;
  owner_e              owner_q;
  logic                we_q;
  logic [AW-1:0]       addr_q;
  logic [DW-1:0]       wdata_q;
  logic [SW-1:0]       wstrb_q;
  logic                mem_req_q;
  logic                if_ack_q;
  logic                d_ack_q;
  logic [DW-1:0]       if_rdata_q;
  logic [DW-1:0]       d_rdata_q;
  logic [STARVE_W-1:0] starve_q;
  logic                discard_q;

  logic i_elig;
  logic grant_i;
  logic grant_d;
  logic kill_own;
  logic keep_i;
  logic to_abort;

  // D is older and wins unless absent or I has waited STARVE_MAX grants.
  assign i_elig   = bus.if_req & ~bus.if_kill;
  assign grant_i  = i_elig & (~bus.d_req | (starve_q == STARVE_LIM));
  assign grant_d  = bus.d_req & ~grant_i;
  assign kill_own = bus.if_kill & (owner_q == OWN_I) & (state_q != IDLE);
  // A killed fetch still finishes the memory handshake but never reports back.
  assign keep_i   = ~discard_q & ~kill_own;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC);

  logic [TO_W-1:0] to_cnt_q;
  logic            if_err_q;
  logic            d_err_q;

  assign to_abort = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) &
                    ((state_q == REQ) | ((state_q == RESP) & ~bus.mem_rvalid));
`else
  assign to_abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_I;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      mem_req_q  <= 1'b0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      starve_q   <= '0;
      discard_q  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      to_cnt_q   <= '0;
      if_err_q   <= 1'b0;
      d_err_q    <= 1'b0;
`endif
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;

      if (!bus.if_req) begin
        starve_q <= '0;
      end else if (state_q == IDLE && grant_i) begin
        starve_q <= '0;
      end else if (state_q == IDLE && grant_d && !bus.if_kill) begin
        starve_q <= sat_inc(starve_q, STARVE_LIM);
      end

      if (kill_own) begin
        discard_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (grant_i || grant_d) begin
            owner_q   <= grant_i ? OWN_I : OWN_D;
            addr_q    <= grant_i ? bus.if_addr : bus.d_addr;
            we_q      <= grant_d & bus.d_we;
            wdata_q   <= grant_i ? '0 : bus.d_wdata;
            wstrb_q   <= grant_i ? '0 : bus.d_wstrb;
            mem_req_q <= 1'b1;
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (to_abort) begin
            mem_req_q <= 1'b0;
            state_q   <= ACK;
          end else if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= RESP;
          end
        end
        RESP: begin
          if (bus.mem_rvalid || to_abort) begin
            state_q <= ACK;
          end
        end
        ACK: begin
          discard_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Completion (normal or aborted) on the transition into ACK.
      if (to_abort || (state_q == RESP && bus.mem_rvalid)) begin
        if (owner_q == OWN_D) begin
          d_ack_q   <= 1'b1;
          d_rdata_q <= (we_q || to_abort) ? '0 : bus.mem_rdata;
        end else if (keep_i) begin
          if_ack_q   <= 1'b1;
          if_rdata_q <= to_abort ? '0 : bus.mem_rdata;
        end
      end

`ifdef MEM_ARB_TIMEOUT_EN
      if (state_q == REQ || state_q == RESP) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end else begin
        to_cnt_q <= '0;
      end
      if_err_q <= to_abort & (owner_q == OWN_I) & keep_i;
      d_err_q  <= to_abort & (owner_q == OWN_D);
`endif
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;

  assign bus.if_ack   = if_ack_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_ack    = d_ack_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.if_stall = bus.if_req & ~if_ack_q & ~bus.if_kill;
  assign bus.d_stall  = bus.d_req & ~d_ack_q;

`ifdef MEM_ARB_TIMEOUT_EN
  assign bus.if_err = if_err_q;
  assign bus.d_err  = d_err_q;
`else
  assign bus.if_err = 1'b0;
  assign bus.d_err  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: the bench plays both requesters and the memory.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mem_port_arb;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;

  // Expected owner of each grant with both requesters held busy (1 = D).
  bit exp_d [0:9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  mem_port_arb_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arb #(
    .AW(AW), .DW(DW), .STARVE_MAX(4), .TIMEOUT_CYC(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b0;
    bus.if_req     = 1'b0;
    bus.if_addr    = '0;
    bus.if_kill    = 1'b0;
    bus.d_req      = 1'b0;
    bus.d_we       = 1'b0;
    bus.d_addr     = '0;
    bus.d_wdata    = '0;
    bus.d_wstrb    = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    repeat (2) tick();

    // Reset state
    chk("rst_mem_req",  bus.mem_req,  32'h0);
    chk("rst_if_ack",   bus.if_ack,   32'h0);
    chk("rst_d_ack",    bus.d_ack,    32'h0);
    chk("rst_if_rdata", bus.if_rdata, 32'h0);
    chk("rst_d_rdata",  bus.d_rdata,  32'h0);
    chk("rst_if_err",   bus.if_err,   32'h0);
    chk("rst_d_err",    bus.d_err,    32'h0);
    rst = 1'b1;
    tick();
    chk("idle_mem_req", bus.mem_req, 32'h0);

    // Lone fetch: IDLE, REQ, RESP, ACK
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    #1 chk("t1_stall_idle", bus.if_stall, 32'h1);
    tick();
    chk("t1_req_c1",  bus.mem_req,  32'h1);
    chk("t1_addr",    bus.mem_addr, 32'h100);
    chk("t1_we",      bus.mem_we,   32'h0);
    chk("t1_ack_c1",  bus.if_ack,   32'h0);
    bus.mem_gnt = 1'b1;
    tick();
    chk("t1_req_c2",  bus.mem_req,  32'h0);
    chk("t1_ack_c2",  bus.if_ack,   32'h0);
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEADBEEF;
    tick();
    chk("t1_ack_c3",   bus.if_ack,   32'h1);
    chk("t1_rdata",    bus.if_rdata, 32'hDEADBEEF);
    chk("t1_d_ack",    bus.d_ack,    32'h0);
    chk("t1_stall_ack", bus.if_stall, 32'h0);
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    bus.if_req     = 1'b0;
    tick();
    chk("t1_ack_c4", bus.if_ack,  32'h0);
    chk("t1_req_c4", bus.mem_req, 32'h0);

    // Both held: D,D,D,D,I repeating
    bus.if_addr = 32'h400;
    bus.d_addr  = 32'h800;
    bus.d_we    = 1'b0;
    bus.if_req  = 1'b1;
    bus.d_req   = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t2_stall_idle%0d", k), bus.if_stall, 32'h1);
      tick();
      chk($sformatf("t2_addr%0d", k), bus.mem_addr, exp_d[k] ? 32'h800 : 32'h400);
      bus.mem_gnt = 1'b1;
      tick();
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hA000 + 32'(k);
      chk($sformatf("t2_stall_resp%0d", k), bus.if_stall, 32'h1);
      tick();
      bus.mem_rvalid = 1'b0;
      chk($sformatf("t2_if_ack%0d", k), bus.if_ack,   exp_d[k] ? 32'h0 : 32'h1);
      chk($sformatf("t2_d_ack%0d", k),  bus.d_ack,    exp_d[k] ? 32'h1 : 32'h0);
      chk($sformatf("t2_stall_ack%0d", k), bus.if_stall, exp_d[k] ? 32'h1 : 32'h0);
      if (!exp_d[k]) chk($sformatf("t2_if_rdata%0d", k), bus.if_rdata, 32'hA000 + 32'(k));
      tick();
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    tick();

    // Fetch killed in RESP, late rvalid, pending D served next
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h300;
    tick();
    chk("t3_addr", bus.mem_addr, 32'h300);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    bus.if_kill = 1'b1;
    bus.d_req   = 1'b1;
    bus.d_addr  = 32'h2400;
    #1 chk("t3_stall_kill", bus.if_stall, 32'h0);
    tick();
    bus.if_kill = 1'b0;
    bus.if_req  = 1'b0;
    tick();
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBAD0BAD0;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("t3_no_if_ack", bus.if_ack,   32'h0);
    chk("t3_no_d_ack",  bus.d_ack,    32'h0);
    chk("t3_rdata_kept", bus.if_rdata, 32'hA009);
    tick();
    chk("t3_idle_req", bus.mem_req, 32'h0);
    chk("t3_idle_ack", bus.if_ack,  32'h0);
    tick();
    chk("t3_d_req",  bus.mem_req,  32'h1);
    chk("t3_d_addr", bus.mem_addr, 32'h2400);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFEF00D;
    tick();
    chk("t3_d_ack",   bus.d_ack,   32'h1);
    chk("t3_d_rdata", bus.d_rdata, 32'hCAFEF00D);
    chk("t3_if_ack",  bus.if_ack,  32'h0);
    bus.mem_rvalid = 1'b0;
    bus.d_req      = 1'b0;
    tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: abort 8 cycles after REQ entry
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h3000;
    tick();
    bus.mem_gnt = 1'b1;
    chk("t7_ack_r0", bus.d_ack, 32'h0);
    tick();
    bus.mem_gnt = 1'b0;
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("t7_ack_r%0d", i), bus.d_ack, 32'h0);
      tick();
    end
    chk("t7_d_ack",   bus.d_ack,   32'h1);
    chk("t7_d_err",   bus.d_err,   32'h1);
    chk("t7_d_rdata", bus.d_rdata, 32'h0);
    chk("t7_mem_req", bus.mem_req, 32'h0);
    bus.d_req = 1'b0;
    tick();
    chk("t7_ack_off", bus.d_ack, 32'h0);
    chk("t7_err_off", bus.d_err, 32'h0);
`endif

    // Write with grant delayed 5 cycles
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h2000;
    bus.d_wdata = 32'h12345678;
    bus.d_wstrb = 4'hF;
    tick();
    chk("t4_we", bus.mem_we, 32'h1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t4_req%0d", i),   bus.mem_req,   32'h1);
      chk($sformatf("t4_addr%0d", i),  bus.mem_addr,  32'h2000);
      chk($sformatf("t4_wdata%0d", i), bus.mem_wdata, 32'h12345678);
      chk($sformatf("t4_wstrb%0d", i), bus.mem_wstrb, 32'hF);
      if (i == 5) bus.mem_gnt = 1'b1;
      tick();
    end
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hFFFFFFFF;
    tick();
    chk("t4_d_ack",   bus.d_ack,   32'h1);
    chk("t4_d_rdata", bus.d_rdata, 32'h0);
    chk("t4_d_stall", bus.d_stall, 32'h0);
    bus.mem_rvalid = 1'b0;
    bus.d_req      = 1'b0;
    bus.d_we       = 1'b0;
    tick();

    // Reset in RESP; a stale rvalid afterwards must be ignored
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h500;
    tick();
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    rst = 1'b0;
    tick();
    chk("t5_req",      bus.mem_req,  32'h0);
    chk("t5_if_ack",   bus.if_ack,   32'h0);
    chk("t5_d_ack",    bus.d_ack,    32'h0);
    chk("t5_if_rdata", bus.if_rdata, 32'h0);
    rst            = 1'b1;
    bus.if_req     = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5555;
    tick();
    chk("t5_stale_if_ack", bus.if_ack,  32'h0);
    chk("t5_stale_d_ack",  bus.d_ack,   32'h0);
    chk("t5_stale_req",    bus.mem_req, 32'h0);
    bus.mem_rvalid = 1'b0;
    tick();
    chk("t5_stale_ack2", bus.if_ack, 32'h0);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h600;
    tick();
    chk("t5_new_req",  bus.mem_req,  32'h1);
    chk("t5_new_addr", bus.mem_addr, 32'h600);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h66;
    tick();
    chk("t5_new_ack",   bus.if_ack,   32'h1);
    chk("t5_new_rdata", bus.if_rdata, 32'h66);
    bus.mem_rvalid = 1'b0;
    bus.if_req     = 1'b0;
    tick();

    // Fetch with if_kill in the same IDLE cycle is not eligible
    bus.if_req  = 1'b1;
    bus.if_kill = 1'b1;
    #1 chk("t6_stall", bus.if_stall, 32'h0);
    tick();
    chk("t6_no_req", bus.mem_req, 32'h0);
    bus.if_req  = 1'b0;
    bus.if_kill = 1'b0;
    tick();
    chk("t6_if_err", bus.if_err, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
